guess_game_ctrl: RTL and testbench

GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

---
 rtl/guess_game_pkg.sv | 41 ++++
 rtl/bcd_counter3.sv | 43 ++++
 rtl/guess_game_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_game_pkg.sv
// Shared definitions for the number-guessing game controller: FSM encoding,
// keypad codes, verdict codes and keypad decode helpers.
package guess_game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    CHECK = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } game_state_e;

  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;
  localparam logic [3:0] KEY_START = 4'd12;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  localparam logic [1:0] TIMES_NONE = 2'b00;
  localparam logic [1:0] TIMES_LOW  = 2'b01;
  localparam logic [1:0] TIMES_HIGH = 2'b10;
  localparam logic [1:0] TIMES_WIN  = 2'b11;

  localparam logic [3:0] BCD_NINE = 4'd9;

  function automatic logic isOneHot(input logic [15:0] keys);
    return (keys != 16'd0) && ((keys & (keys - 16'd1)) == 16'd0);
  endfunction

  // Only meaningful when isOneHot() holds for the same vector.
  function automatic logic [3:0] keyIndex(input logic [15:0] keys);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (keys[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Free-running three-digit BCD counter, 000..999 then wrap; its value at the
// moment START is pressed becomes the secret number.
module bcd_counter3
  import guess_game_pkg::*;
(
  input  logic        clk_50M,
  input  logic        RSTn,
  output logic [11:0] count
);

  logic [11:0] count_q;
  logic [11:0] count_d;

  always_comb begin
    count_d = count_q;
    if (count_q[3:0] != BCD_NINE) begin
      count_d[3:0] = count_q[3:0] + 4'd1;
    end else begin
      count_d[3:0] = 4'd0;
      if (count_q[7:4] != BCD_NINE) begin
        count_d[7:4] = count_q[7:4] + 4'd1;
      end else begin
        count_d[7:4] = 4'd0;
        if (count_q[11:8] != BCD_NINE) begin
          count_d[11:8] = count_q[11:8] + 4'd1;
        end else begin
          count_d[11:8] = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk_50M or negedge RSTn) begin
    if (!RSTn) begin
      count_q <= 12'h000;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller: keypad edge detect, game FSM, BCD entry
// register, secret comparator and buzzer timer.
module guess_game_ctrl
  import guess_game_pkg::*;
#(
  parameter int MAX_TRIES  = 8,
  parameter int BUZZ_SHORT = 5_000_000,
  parameter int BUZZ_LONG  = 25_000_000
) (
  input  logic        clk_50M,
  input  logic        RSTn,
  input  logic [15:0] key_deb,
  output logic [11:0] data_disp,
  output logic [3:0]  tries,
  output logic [1:0]  times,
  output logic        buzzer,
  output logic [2:0]  game_state
);

  localparam int BUZZ_MAX = (BUZZ_LONG > BUZZ_SHORT) ? BUZZ_LONG : BUZZ_SHORT;
  localparam int BUZZ_W   = $clog2(BUZZ_MAX + 1);
  localparam logic [BUZZ_W-1:0] BUZZ_SHORT_V = BUZZ_W'(BUZZ_SHORT);
  localparam logic [BUZZ_W-1:0] BUZZ_LONG_V  = BUZZ_W'(BUZZ_LONG);
  localparam logic [BUZZ_W-1:0] BUZZ_ONE     = BUZZ_W'(1);
  localparam logic [3:0]        TRIES_MAX    = 4'(MAX_TRIES);

  game_state_e       state_q, state_d;
  logic [15:0]       keyPrev_q;
  logic [11:0]       secret_q, secret_d;
  logic [11:0]       entry_q, entry_d;
  logic [1:0]        digitCnt_q, digitCnt_d;
  logic              freshEntry_q, freshEntry_d;
  logic [3:0]        tries_q, tries_d;
  logic [1:0]        times_q, times_d;
  logic [BUZZ_W-1:0] buzzCnt_q, buzzCnt_d;

  logic [11:0] bcdCount;
  logic        keyEvent;
  logic [3:0]  keyCode;
  logic        isDigit, isEnter, isClear, isStart;
  logic [3:0]  triesInc;
  logic        guessEqual, guessLow;

  bcd_counter3 uBcdCounter (
    .clk_50M (clk_50M),
    .RSTn    (RSTn),
    .count   (bcdCount)
  );

  // A key fires only on the idle-to-single-key transition, so holds,
  // releases and chords never produce events.
  assign keyEvent = isOneHot(key_deb) && (keyPrev_q == 16'd0);
  assign keyCode  = keyIndex(key_deb);
  assign isDigit  = keyEvent && (keyCode <= KEY_DIGIT_MAX);
  assign isEnter  = keyEvent && (keyCode == KEY_ENTER);
  assign isClear  = keyEvent && (keyCode == KEY_CLEAR);
  assign isStart  = keyEvent && (keyCode == KEY_START);

  assign triesInc   = (tries_q >= TRIES_MAX) ? TRIES_MAX : tries_q + 4'd1;
  assign guessEqual = (entry_q == secret_q);
  assign guessLow   = (entry_q < secret_q);

  always_ff @(posedge clk_50M or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WIN, LOSE: begin
        if (isStart) begin
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (isStart) begin
          state_d = ENTRY;
        end else if (isEnter && (digitCnt_q != 2'd0)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (guessEqual) begin
          state_d = WIN;
        end else if (triesInc == TRIES_MAX) begin
          state_d = LOSE;
        end else begin
          state_d = ENTRY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state; the buzzer timer counts down unless reloaded.
  always_comb begin
    secret_d     = secret_q;
    entry_d      = entry_q;
    digitCnt_d   = digitCnt_q;
    freshEntry_d = freshEntry_q;
    tries_d      = tries_q;
    times_d      = times_q;
    buzzCnt_d    = (buzzCnt_q != '0) ? buzzCnt_q - BUZZ_ONE : '0;

    if (isStart && (state_q != CHECK)) begin
      secret_d     = bcdCount;
      entry_d      = 12'h000;
      digitCnt_d   = 2'd0;
      freshEntry_d = 1'b0;
      tries_d      = 4'd0;
      times_d      = TIMES_NONE;
      buzzCnt_d    = '0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (isDigit) begin
            if (freshEntry_q) begin
              entry_d      = {8'h00, keyCode};
              digitCnt_d   = 2'd1;
              freshEntry_d = 1'b0;
              times_d      = TIMES_NONE;
            end else begin
              entry_d    = {entry_q[7:0], keyCode};
              digitCnt_d = (digitCnt_q == 2'd3) ? 2'd3 : digitCnt_q + 2'd1;
            end
          end else if (isClear) begin
            entry_d    = 12'h000;
            digitCnt_d = 2'd0;
          end
        end
        CHECK: begin
          // The guess stays on display until the next digit starts over.
          tries_d      = triesInc;
          digitCnt_d   = 2'd0;
          freshEntry_d = 1'b1;
          if (guessEqual) begin
            times_d   = TIMES_WIN;
            buzzCnt_d = BUZZ_LONG_V;
          end else begin
            times_d   = guessLow ? TIMES_LOW : TIMES_HIGH;
            buzzCnt_d = (triesInc == TRIES_MAX) ? BUZZ_LONG_V : BUZZ_SHORT_V;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge RSTn) begin
    if (!RSTn) begin
      keyPrev_q    <= 16'd0;
      secret_q     <= 12'h000;
      entry_q      <= 12'h000;
      digitCnt_q   <= 2'd0;
      freshEntry_q <= 1'b0;
      tries_q      <= 4'd0;
      times_q      <= TIMES_NONE;
      buzzCnt_q    <= '0;
    end else begin
      keyPrev_q    <= key_deb;
      secret_q     <= secret_d;
      entry_q      <= entry_d;
      digitCnt_q   <= digitCnt_d;
      freshEntry_q <= freshEntry_d;
      tries_q      <= tries_d;
      times_q      <= times_d;
      buzzCnt_q    <= buzzCnt_d;
    end
  end

  always_comb begin
    unique case (state_q)
      IDLE:      data_disp = 12'h000;
      WIN, LOSE: data_disp = secret_q;
      default:   data_disp = entry_q;
    endcase
  end

  assign tries      = tries_q;
  assign times      = times_q;
  assign buzzer     = (buzzCnt_q != '0);
  assign game_state = state_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Scoreboard bench for guess_game_ctrl: directed key sequences queue their
// expected outputs, and a negedge monitor pops and compares them.
module tb_guess_game_ctrl;
  import guess_game_pkg::*;

  localparam int MAX_TRIES  = 2;
  localparam int BUZZ_SHORT = 5;
  localparam int BUZZ_LONG  = 12;

  localparam logic [4:0] M_DISP  = 5'b00001;
  localparam logic [4:0] M_TRIES = 5'b00010;
  localparam logic [4:0] M_TIMES = 5'b00100;
  localparam logic [4:0] M_STATE = 5'b01000;
  localparam logic [4:0] M_BUZZ  = 5'b10000;
  localparam logic [4:0] M_ALL   = 5'b11111;

  logic        clk_50M = 1'b0;
  logic        RSTn    = 1'b1;
  logic [15:0] key_deb = 16'd0;
  logic [11:0] data_disp;
  logic [3:0]  tries;
  logic [1:0]  times;
  logic        buzzer;
  logic [2:0]  game_state;

  typedef struct {
    string      name;
    int         due;
    logic [4:0] mask;
    logic [11:0] disp;
    logic [3:0] tries;
    logic [1:0] times;
    logic [2:0] state;
    logic       buzz;
  } exp_t;

  exp_t expQ[$];
  exp_t curExp;
  int   tbCycle  = 0;
  int   refCount = 0;
  int   total    = 0;
  int   bad      = 0;

  guess_game_ctrl #(
    .MAX_TRIES  (MAX_TRIES),
    .BUZZ_SHORT (BUZZ_SHORT),
    .BUZZ_LONG  (BUZZ_LONG)
  ) dut (
    .clk_50M    (clk_50M),
    .RSTn       (RSTn),
    .key_deb    (key_deb),
    .data_disp  (data_disp),
    .tries      (tries),
    .times      (times),
    .buzzer     (buzzer),
    .game_state (game_state)
  );

  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) tbCycle <= tbCycle + 1;

  // Reference secret source: the value a free-running decimal counter holds.
  always @(posedge clk_50M or negedge RSTn) begin
    if (!RSTn) refCount <= 0;
    else       refCount <= (refCount + 1) % 1000;
  end

  task automatic checkOutput(input exp_t e);
    logic ok;
    ok = 1'b1;
    if (e.mask[0] && (data_disp  !== e.disp))  ok = 1'b0;
    if (e.mask[1] && (tries      !== e.tries)) ok = 1'b0;
    if (e.mask[2] && (times      !== e.times)) ok = 1'b0;
    if (e.mask[3] && (game_state !== e.state)) ok = 1'b0;
    if (e.mask[4] && (buzzer     !== e.buzz))  ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d mask=%b got disp=%h tries=%0d times=%b state=%0d buzz=%b want disp=%h tries=%0d times=%b state=%0d buzz=%b",
               e.name, tbCycle, e.mask, data_disp, tries, times, game_state, buzzer,
               e.disp, e.tries, e.times, e.state, e.buzz);
    end
  endtask

  always @(negedge clk_50M) begin
    while (expQ.size() > 0 && expQ[0].due <= tbCycle) begin
      curExp = expQ.pop_front();
      checkOutput(curExp);
    end
  end

  task automatic expectAt(input int off, input string name, input logic [4:0] mask,
                          input logic [11:0] disp, input logic [3:0] tr,
                          input logic [1:0] tm, input logic [2:0] st, input logic bz);
    exp_t e;
    e.name  = name;
    e.due   = tbCycle + off;
    e.mask  = mask;
    e.disp  = disp;
    e.tries = tr;
    e.times = tm;
    e.state = st;
    e.buzz  = bz;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [15:0] pattern, input int hold);
    key_deb = pattern;
    repeat (hold) @(negedge clk_50M);
    key_deb = 16'd0;
    @(negedge clk_50M);
  endtask

  task automatic pressKey(input logic [3:0] k);
    logic [15:0] one;
    one = 16'h0001;
    applyStimulus(one << k, 1);
  endtask

  task automatic startGame(input int target);
    int guard;
    guard = 0;
    while (refCount != target && guard < 1100) begin
      @(negedge clk_50M);
      guard++;
    end
    if (refCount != target) begin
      total++;
      bad++;
      $display("[TB] FAIL secret-wait got count=%0d want %0d", refCount, target);
    end
    expectAt(1, "start", M_ALL, 12'h000, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(KEY_START);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    #1 RSTn = 1'b0;
    @(negedge clk_50M);
    expectAt(1, "reset idle", M_ALL, 12'h000, 4'd0, TIMES_NONE, IDLE, 1'b0);
    @(negedge clk_50M);
    #5 RSTn = 1'b1;
    @(negedge clk_50M);

    $display("[TB] game 1: secret 001 taken right after reset, win on first try");
    startGame(1);
    expectAt(1, "g1 digit 1", M_DISP | M_STATE, 12'h001, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd1);
    expectAt(1, "g1 check", M_STATE, 12'h000, 4'd0, TIMES_NONE, CHECK, 1'b0);
    expectAt(2, "g1 win", M_ALL, 12'h001, 4'd1, TIMES_WIN, WIN, 1'b1);
    pressKey(KEY_ENTER);
    expectAt(1, "g1 win ignores digit", M_DISP | M_TRIES | M_STATE, 12'h001, 4'd1, TIMES_WIN, WIN, 1'b0);
    pressKey(4'd3);

    $display("[TB] game 2: secret 427, guess 300");
    startGame(427);
    expectAt(1, "g2 digit 3", M_DISP, 12'h003, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd3);
    expectAt(1, "g2 digit 0", M_DISP, 12'h030, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd0);
    expectAt(1, "g2 digit 0b", M_DISP, 12'h300, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd0);
    expectAt(1, "g2 check", M_STATE, 12'h000, 4'd0, TIMES_NONE, CHECK, 1'b0);
    expectAt(2, "g2 too low", M_ALL, 12'h300, 4'd1, TIMES_LOW, ENTRY, 1'b1);
    for (int k = 3; k <= BUZZ_SHORT + 1; k++)
      expectAt(k, "g2 short buzz on", M_BUZZ, 12'h000, 4'd0, TIMES_NONE, IDLE, 1'b1);
    expectAt(BUZZ_SHORT + 2, "g2 short buzz off", M_BUZZ, 12'h000, 4'd0, TIMES_NONE, IDLE, 1'b0);
    pressKey(KEY_ENTER);
    repeat (BUZZ_SHORT + 1) @(negedge clk_50M);

    $display("[TB] game 3: secret 427, guess 005 then 427");
    startGame(427);
    expectAt(1, "g3 digit 5", M_DISP, 12'h005, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd5);
    expectAt(2, "g3 005 low", M_ALL, 12'h005, 4'd1, TIMES_LOW, ENTRY, 1'b1);
    pressKey(KEY_ENTER);
    expectAt(1, "g3 fresh entry", M_DISP | M_TIMES | M_TRIES, 12'h004, 4'd1, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd4);
    expectAt(1, "g3 digit 2", M_DISP, 12'h042, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd2);
    expectAt(1, "g3 digit 7", M_DISP, 12'h427, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd7);
    expectAt(1, "g3 check", M_STATE, 12'h000, 4'd0, TIMES_NONE, CHECK, 1'b0);
    expectAt(2, "g3 win", M_ALL, 12'h427, 4'd2, TIMES_WIN, WIN, 1'b1);
    for (int k = 3; k <= BUZZ_LONG + 1; k++)
      expectAt(k, "g3 long buzz on", M_BUZZ, 12'h000, 4'd0, TIMES_NONE, IDLE, 1'b1);
    expectAt(BUZZ_LONG + 2, "g3 long buzz off", M_BUZZ, 12'h000, 4'd0, TIMES_NONE, IDLE, 1'b0);
    pressKey(KEY_ENTER);
    repeat (BUZZ_LONG + 1) @(negedge clk_50M);

    $display("[TB] game 4: secret 100, guesses 050 and 200 exhaust the tries");
    startGame(100);
    pressKey(4'd0);
    pressKey(4'd5);
    expectAt(1, "g4 digit 0", M_DISP, 12'h050, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd0);
    expectAt(2, "g4 050 low", M_ALL, 12'h050, 4'd1, TIMES_LOW, ENTRY, 1'b1);
    pressKey(KEY_ENTER);
    expectAt(1, "g4 fresh 2", M_DISP | M_TIMES, 12'h002, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd2);
    pressKey(4'd0);
    expectAt(1, "g4 digit 0", M_DISP, 12'h200, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd0);
    expectAt(1, "g4 check", M_STATE, 12'h000, 4'd0, TIMES_NONE, CHECK, 1'b0);
    expectAt(2, "g4 lose", M_ALL, 12'h100, 4'd2, TIMES_HIGH, LOSE, 1'b1);
    pressKey(KEY_ENTER);
    expectAt(1, "g4 lose ignores digit", M_ALL, 12'h100, 4'd2, TIMES_HIGH, LOSE, 1'b1);
    pressKey(4'd9);
    expectAt(1, "g4 start stops buzz", M_ALL, 12'h000, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(KEY_START);

    $display("[TB] game 5: shifting, clear, empty enter, chords and holds");
    expectAt(1, "g5 digit 1", M_DISP, 12'h001, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd1);
    expectAt(1, "g5 digit 2", M_DISP, 12'h012, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd2);
    expectAt(1, "g5 digit 3", M_DISP, 12'h123, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd3);
    expectAt(1, "g5 fourth digit", M_DISP, 12'h234, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd4);
    expectAt(1, "g5 clear", M_ALL, 12'h000, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(KEY_CLEAR);
    expectAt(1, "g5 empty enter no check", M_STATE, 12'h000, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    expectAt(2, "g5 empty enter tries", M_STATE | M_TRIES, 12'h000, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(KEY_ENTER);
    expectAt(1, "g5 chord ignored", M_DISP, 12'h000, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    expectAt(2, "g5 chord release", M_DISP, 12'h000, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    applyStimulus(16'h0003, 1);
    expectAt(1, "g5 hold first", M_DISP, 12'h005, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    expectAt(50, "g5 hold mid", M_DISP, 12'h005, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    expectAt(101, "g5 hold release", M_DISP, 12'h005, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    applyStimulus(16'h0020, 100);
    expectAt(1, "g5 key 13 ignored", M_DISP | M_STATE, 12'h005, 4'd0, TIMES_NONE, ENTRY, 1'b0);
    pressKey(4'd13);

    $display("[TB] game 6: reset during the wrong-guess buzz");
    startGame(700);
    pressKey(4'd5);
    expectAt(2, "g6 005 low", M_ALL, 12'h005, 4'd1, TIMES_LOW, ENTRY, 1'b1);
    pressKey(KEY_ENTER);
    @(posedge clk_50M);
    #2 RSTn = 1'b0;
    expectAt(0, "g6 async reset", M_ALL, 12'h000, 4'd0, TIMES_NONE, IDLE, 1'b0);
    @(negedge clk_50M);
    #3 RSTn = 1'b1;
    @(negedge clk_50M);
    expectAt(1, "g6 idle ignores digit", M_ALL, 12'h000, 4'd0, TIMES_NONE, IDLE, 1'b0);
    pressKey(4'd5);
    expectAt(1, "g6 idle ignores enter", M_ALL, 12'h000, 4'd0, TIMES_NONE, IDLE, 1'b0);
    pressKey(KEY_ENTER);

    guard = 0;
    while (expQ.size() > 0 && guard < 200) begin
      @(negedge clk_50M);
      guard++;
    end
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain got pending=%0d want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
